// File: rtl/constants_pkg.sv
// Argon register-file bus command encodings, shared by bus initiators and targets.
package constants_pkg;

  localparam int unsigned COM_W = 4;

  localparam logic [COM_W-1:0] COM_NOP      = 4'd0;
  localparam logic [COM_W-1:0] COM_LATCHSEL = 4'd1;
  localparam logic [COM_W-1:0] COM_READA    = 4'd2;
  localparam logic [COM_W-1:0] COM_LATCHC   = 4'd3;

endpackage

// File: rtl/regfile_bus_master.sv
// Argon register-file bus initiator: expands MOVE/LOADI/READ micro-ops into LATCHSEL/READA/LATCHC.
// Optional read-valid timeout enabled by defining REGFILE_BUS_MASTER_TIMEOUT_EN.
module regfile_bus_master
  import constants_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH = 3,
  parameter int unsigned CMD_WIDTH   = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [1:0]             i_req_op,
  input  logic [INDEX_WIDTH-1:0] i_req_sel_a,
  input  logic [INDEX_WIDTH-1:0] i_req_sel_c,
  input  logic [DATA_WIDTH-1:0]  i_req_imm,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [DATA_WIDTH-1:0]  o_rsp_data,
  output logic                   o_rsp_error,
  output logic [CMD_WIDTH-1:0]   o_bus_command,
  output logic [DATA_WIDTH-1:0]  o_bus_data,
  output logic                   o_bus_valid,
  input  logic [DATA_WIDTH-1:0]  i_bus_data,
  input  logic                   i_bus_valid,
  input  logic                   i_bus_error
);

  localparam int unsigned OP_W   = 2;
  localparam int unsigned WAIT_W = 8;

  localparam logic [OP_W-1:0] OP_MOVE  = 2'd0;
  localparam logic [OP_W-1:0] OP_LOADI = 2'd1;
  localparam logic [OP_W-1:0] OP_RSVD  = 2'd3;

  localparam logic [CMD_WIDTH-1:0] CMD_NOP      = CMD_WIDTH'(COM_NOP);
  localparam logic [CMD_WIDTH-1:0] CMD_LATCHSEL = CMD_WIDTH'(COM_LATCHSEL);
  localparam logic [CMD_WIDTH-1:0] CMD_READA    = CMD_WIDTH'(COM_READA);
  localparam logic [CMD_WIDTH-1:0] CMD_LATCHC   = CMD_WIDTH'(COM_LATCHC);

  if (TIMEOUT == 0 || TIMEOUT > 255 || DATA_WIDTH < 3 * INDEX_WIDTH) begin : g_bad_params
    $error("regfile_bus_master: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_READ,
    ST_WRITE,
    ST_RSP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [OP_W-1:0]        r_op, w_op_nxt;
  logic [INDEX_WIDTH-1:0] r_sel_a, w_sel_a_nxt;
  logic [INDEX_WIDTH-1:0] r_sel_c, w_sel_c_nxt;
  logic [DATA_WIDTH-1:0]  r_data, w_data_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_req_ready, w_req_ready_nxt;
  logic                   r_rsp_valid, w_rsp_valid_nxt;
  logic [CMD_WIDTH-1:0]   r_bus_cmd, w_bus_cmd_nxt;
  logic [DATA_WIDTH-1:0]  r_bus_data, w_bus_data_nxt;
  logic                   r_bus_valid, w_bus_valid_nxt;
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  logic [WAIT_W-1:0]      r_wait, w_wait_nxt;
`endif

  // Next state, transaction registers and the registered bus/handshake outputs they imply.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_sel_a_nxt     = r_sel_a;
    w_sel_c_nxt     = r_sel_c;
    w_data_nxt      = r_data;
    w_err_nxt       = r_err;
    w_bus_cmd_nxt   = CMD_NOP;
    w_bus_data_nxt  = '0;
    w_bus_valid_nxt = 1'b0;
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
    w_wait_nxt      = r_wait;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_op_nxt    = i_req_op;
          w_sel_a_nxt = i_req_sel_a;
          w_sel_c_nxt = i_req_sel_c;
          w_data_nxt  = (i_req_op == OP_LOADI) ? i_req_imm : '0;
          w_err_nxt   = (i_req_op == OP_RSVD);
          w_state_nxt = (i_req_op == OP_RSVD) ? ST_RSP : ST_SEL;
        end
      end
      ST_SEL: begin
        w_state_nxt = (r_op == OP_LOADI) ? ST_WRITE : ST_READ;
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
        w_wait_nxt  = '0;
`endif
      end
      ST_READ: begin
        if (i_bus_valid) begin
          w_data_nxt  = i_bus_data;
          w_state_nxt = (r_op == OP_MOVE) ? ST_WRITE : ST_RSP;
        end
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
        else if (r_wait == WAIT_LAST) begin
          // Abandon the read; a MOVE never reaches LATCHC so the destination is untouched.
          w_data_nxt  = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RSP;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
`endif
      end
      ST_WRITE: w_state_nxt = ST_RSP;
      ST_RSP:   if (i_rsp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase

    if (i_bus_error && (r_state inside {ST_SEL, ST_READ, ST_WRITE})) w_err_nxt = 1'b1;

    case (w_state_nxt)
      ST_SEL: begin
        w_bus_cmd_nxt   = CMD_LATCHSEL;
        w_bus_data_nxt  = DATA_WIDTH'({w_sel_c_nxt, {INDEX_WIDTH{1'b0}}, w_sel_a_nxt});
        w_bus_valid_nxt = 1'b1;
      end
      ST_READ: w_bus_cmd_nxt = CMD_READA;
      ST_WRITE: begin
        w_bus_cmd_nxt   = CMD_LATCHC;
        w_bus_data_nxt  = w_data_nxt;
        w_bus_valid_nxt = 1'b1;
      end
      default: w_bus_cmd_nxt = CMD_NOP;
    endcase

    w_req_ready_nxt = (w_state_nxt == ST_IDLE);
    w_rsp_valid_nxt = (w_state_nxt == ST_RSP);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_MOVE;
      r_sel_a     <= '0;
      r_sel_c     <= '0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_bus_cmd   <= CMD_NOP;
      r_bus_data  <= '0;
      r_bus_valid <= 1'b0;
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
      r_wait      <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_sel_a     <= w_sel_a_nxt;
      r_sel_c     <= w_sel_c_nxt;
      r_data      <= w_data_nxt;
      r_err       <= w_err_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_bus_cmd   <= w_bus_cmd_nxt;
      r_bus_data  <= w_bus_data_nxt;
      r_bus_valid <= w_bus_valid_nxt;
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
      r_wait      <= w_wait_nxt;
`endif
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_data    = r_data;
  assign o_rsp_error   = r_err;
  assign o_bus_command = r_bus_cmd;
  assign o_bus_data    = r_bus_data;
  assign o_bus_valid   = r_bus_valid;

endmodule

// File: tb/tb_regfile_bus_master.sv
// Bench for regfile_bus_master: register-file slave model plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_regfile_bus_master;
  import constants_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;

  localparam logic [1:0] OP_MOVE  = 2'd0;
  localparam logic [1:0] OP_LOADI = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  logic          clk = 1'b0;
  logic          i_Reset_n;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [1:0]    i_req_op;
  logic [IW-1:0] i_req_sel_a;
  logic [IW-1:0] i_req_sel_c;
  logic [DW-1:0] i_req_imm;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_error;
  logic [CW-1:0] o_bus_command;
  logic [DW-1:0] o_bus_data;
  logic          o_bus_valid;
  logic [DW-1:0] i_bus_data;
  logic          i_bus_valid;
  logic          i_bus_error;

  always #5 clk = ~clk;

  regfile_bus_master #(
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW),
    .CMD_WIDTH  (CW),
    .TIMEOUT    (TO)
  ) u_dut (
    .i_Clk        (clk),
    .i_Reset_n    (i_Reset_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op     (i_req_op),
    .i_req_sel_a  (i_req_sel_a),
    .i_req_sel_c  (i_req_sel_c),
    .i_req_imm    (i_req_imm),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_error  (o_rsp_error),
    .o_bus_command(o_bus_command),
    .o_bus_data   (o_bus_data),
    .o_bus_valid  (o_bus_valid),
    .i_bus_data   (i_bus_data),
    .i_bus_valid  (i_bus_valid),
    .i_bus_error  (i_bus_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 0) return '0;
    if (i == 2) return 16'h00AB;
    return DW'(i * 16'h1111);
  endfunction

  // Slave configuration, written by the stimulus process only.
  int            s_waits   = 0;
  bit            s_stuck   = 1'b0;
  bit            s_err_en  = 1'b0;
  logic [CW-1:0] s_err_cmd = COM_NOP;

  // Register-file slave: r0 reads zero and ignores writes.
  logic [DW-1:0] s_rf [8];
  logic [IW-1:0] s_sel_a, s_sel_c;
  bit            s_init_done = 1'b0;
  always @(posedge clk) begin
    if (!s_init_done) begin
      for (int i = 0; i < 8; i++) s_rf[i] = init_val(i);
      s_sel_a     = '0;
      s_sel_c     = '0;
      s_init_done = 1'b1;
    end
    if (o_bus_valid && o_bus_command == COM_LATCHSEL) begin
      s_sel_a = o_bus_data[IW-1:0];
      s_sel_c = o_bus_data[3*IW-1:2*IW];
    end
    if (o_bus_valid && o_bus_command == COM_LATCHC && s_sel_c != '0) s_rf[s_sel_c] = o_bus_data;
  end

  int rd_cnt = 0;
  always @(negedge clk) begin
    i_bus_valid = 1'b0;
    i_bus_data  = '0;
    if (o_bus_command == COM_READA) begin
      if (!s_stuck && rd_cnt >= s_waits) begin
        i_bus_valid = 1'b1;
        i_bus_data  = s_rf[s_sel_a];
      end
      rd_cnt++;
    end else begin
      rd_cnt = 0;
    end
    i_bus_error = s_err_en && (o_bus_command == s_err_cmd);
  end

  logic [DW-1:0] m_rf [8];

  // One micro-op through the DUT, judged against the reference model.
  task automatic run_txn(input logic [1:0] op, input logic [IW-1:0] a, input logic [IW-1:0] c,
                         input logic [DW-1:0] imm, input int waits, input bit stuck,
                         input bit err_en, input logic [CW-1:0] err_cmd, input int hold);
    bit            uses_sel, uses_rd, uses_wr, exp_err, saw_wr, quiet_bad;
    logic [DW-1:0] exp_data, exp_wr, wr_val, held;
    int            exp_lat, lat;

    uses_sel = (op != OP_RSVD);
    uses_rd  = (op == OP_MOVE) || (op == OP_READ);
    uses_wr  = (op == OP_LOADI) || (op == OP_MOVE && !stuck);
    exp_wr   = (op == OP_LOADI) ? imm : m_rf[a];
    exp_err  = (op == OP_RSVD);
    exp_data = (op == OP_LOADI) ? imm : (uses_rd ? m_rf[a] : '0);
    case (op)
      OP_MOVE:  exp_lat = 4 + waits;
      OP_READ:  exp_lat = 3 + waits;
      OP_LOADI: exp_lat = 3;
      default:  exp_lat = 1;
    endcase
    if (stuck && uses_rd) begin
      exp_lat  = 2 + TO;
      exp_data = '0;
      exp_err  = 1'b1;
    end
    if (err_en && ((err_cmd == COM_LATCHSEL && uses_sel) || (err_cmd == COM_READA && uses_rd) ||
                   (err_cmd == COM_LATCHC && uses_wr)))
      exp_err = 1'b1;

    s_waits   = waits;
    s_stuck   = stuck;
    s_err_en  = err_en;
    s_err_cmd = err_cmd;

    check("req_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_op    = op;
    i_req_sel_a = a;
    i_req_sel_c = c;
    i_req_imm   = imm;
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;

    if (uses_sel) begin
      check("sel_cmd", 32'(o_bus_command), 32'(COM_LATCHSEL));
      check("sel_data", 32'(o_bus_data), 32'(int'(c) * 64 + int'(a)));
    end else begin
      check("rsvd_cmd", 32'(o_bus_command), 32'(COM_NOP));
    end

    lat       = 1;
    saw_wr    = 1'b0;
    quiet_bad = 1'b0;
    wr_val    = '0;
    while (!o_rsp_valid && lat < 300) begin
      if (o_bus_command == COM_LATCHC && o_bus_valid) begin
        saw_wr = 1'b1;
        wr_val = o_bus_data;
      end
      if (o_bus_command != COM_LATCHSEL && o_bus_command != COM_LATCHC &&
          (o_bus_valid || o_bus_data != '0)) quiet_bad = 1'b1;
      if (o_req_ready) quiet_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end

    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_data", 32'(o_rsp_data), 32'(exp_data));
    check("rsp_error", 32'(o_rsp_error), 32'(exp_err));
    check("latchc_issued", 32'(saw_wr), 32'(uses_wr));
    check("idle_bus_quiet", 32'(quiet_bad), 32'd0);
    if (saw_wr) check("latchc_data", 32'(wr_val), 32'(exp_wr));

    held = o_rsp_data;
    for (int h = 0; h < hold; h++) begin
      i_rsp_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", 32'(o_rsp_valid), 32'd1);
      check("hold_data", 32'(o_rsp_data), 32'(held));
      check("hold_ready", 32'(o_req_ready), 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("post_req_ready", 32'(o_req_ready), 32'd1);

    if (uses_wr && c != '0) m_rf[c] = exp_wr;
    check("slave_rf", 32'(s_rf[c]), 32'(m_rf[c]));
    s_err_en = 1'b0;
    s_stuck  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] ecmd;
    i_Reset_n   = 1'b0;
    i_req_valid = 1'b0;
    i_req_op    = '0;
    i_req_sel_a = '0;
    i_req_sel_c = '0;
    i_req_imm   = '0;
    i_rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = init_val(i);

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(o_rsp_data), 32'd0);
    check("rst_rsp_error", 32'(o_rsp_error), 32'd0);
    check("rst_bus_cmd", 32'(o_bus_command), 32'(COM_NOP));
    check("rst_bus_data", 32'(o_bus_data), 32'd0);
    check("rst_bus_valid", 32'(o_bus_valid), 32'd0);
    i_Reset_n = 1'b1;
    @(posedge clk); #1;

    run_txn(OP_MOVE,  3'd2, 3'd5, 16'h0000, 0, 1'b0, 1'b0, COM_NOP, 0);
    run_txn(OP_LOADI, 3'd0, 3'd2, 16'h1234, 0, 1'b0, 1'b0, COM_NOP, 0);
    run_txn(OP_READ,  3'd0, 3'd0, 16'h0000, 0, 1'b0, 1'b0, COM_NOP, 0);
    run_txn(OP_READ,  3'd5, 3'd0, 16'h0000, 3, 1'b0, 1'b0, COM_NOP, 0);
    run_txn(OP_LOADI, 3'd0, 3'd0, 16'hBEEF, 0, 1'b0, 1'b0, COM_NOP, 0);
    run_txn(OP_LOADI, 3'd0, 3'd4, 16'h5A5A, 0, 1'b0, 1'b1, COM_LATCHC, 1);
    run_txn(OP_RSVD,  3'd1, 3'd1, 16'hFFFF, 0, 1'b0, 1'b0, COM_NOP, 0);
    run_txn(OP_READ,  3'd4, 3'd0, 16'h0000, 1, 1'b0, 1'b0, COM_NOP, 0);
`ifdef REGFILE_BUS_MASTER_TIMEOUT_EN
    run_txn(OP_MOVE,  3'd3, 3'd6, 16'h0000, 0, 1'b1, 1'b0, COM_NOP, 0);
`endif

    // Reset while the read is still waiting for the slave.
    s_waits     = 10;
    i_req_op    = OP_MOVE;
    i_req_sel_a = 3'd2;
    i_req_sel_c = 3'd7;
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_in_read", 32'(o_bus_command), 32'(COM_READA));
    i_Reset_n = 1'b0;
    @(posedge clk); #1;
    i_Reset_n = 1'b1;
    check("mid_rst_cmd", 32'(o_bus_command), 32'(COM_NOP));
    check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(o_req_ready), 32'd1);
    check("mid_rst_rf", 32'(s_rf[7]), 32'(m_rf[7]));
    run_txn(OP_LOADI, 3'd0, 3'd3, 16'hC0DE, 0, 1'b0, 1'b0, COM_NOP, 5);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(2, 0))
        0:       ecmd = COM_LATCHSEL;
        1:       ecmd = COM_READA;
        default: ecmd = COM_LATCHC;
      endcase
      run_txn(($urandom_range(9, 0) == 0) ? OP_RSVD : 2'($urandom_range(2, 0)),
              IW'($urandom_range(7, 0)), IW'($urandom_range(7, 0)), DW'($urandom),
              int'($urandom_range(3, 0)), 1'b0, ($urandom_range(4, 0) == 0), ecmd,
              int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_bus_master.md
# regfile_bus_master

Bus initiator that drives the Argon register-file bus protocol from the initiating side. It accepts one register micro-operation at a time from the control unit (move, load-immediate, read), expands it into the bus command sequence LATCHSEL → READA → LATCHC, and returns a single response carrying the data word and an error flag. It sits between the control unit and the register file's bus port.

## Interface
Parameters:
- DATA_WIDTH, 16, bus word width
- INDEX_WIDTH, 3, register index width
- CMD_WIDTH, 4, bus command width; encodings COM_NOP, COM_LATCHSEL, COM_READA, COM_LATCHC come from constants_pkg
- TIMEOUT, 15, maximum wait cycles for read-valid; range 1..255

Ports:
- i_Clk  in  1  clock
- i_Reset_n  in  1  reset, one clock domain; reset is synchronous and active-low
- i_req_valid  in  1  request offered
- o_req_ready  out  1  high only in IDLE
- i_req_op  in  2  0 = MOVE (rC←rA), 1 = LOADI (rC←imm), 2 = READ (return rA), 3 = reserved
- i_req_sel_a  in  INDEX_WIDTH  source index
- i_req_sel_c  in  INDEX_WIDTH  destination index
- i_req_imm  in  DATA_WIDTH  immediate for LOADI
- o_rsp_valid  out  1  response held
- i_rsp_ready  in  1  response consumed
- o_rsp_data  out  DATA_WIDTH  moved, loaded or read word
- o_rsp_error  out  1  transaction failed
- o_bus_command  out  CMD_WIDTH  to slave command
- o_bus_data  out  DATA_WIDTH  to slave i_data
- o_bus_valid  out  1  to slave i_valid
- i_bus_data  in  DATA_WIDTH  from slave o_data
- i_bus_valid  in  1  from slave o_valid
- i_bus_error  in  1  from slave error

## Operation
- FSM states: IDLE, SEL, READ, WRITE, RSP.
- IDLE: o_req_ready=1, bus command COM_NOP. On i_req_valid, latch op, indices and imm; op 3 → RSP with error=1, data=0; otherwise → SEL.
- SEL (1 cycle): command COM_LATCHSEL, o_bus_data = {sel_c, sel_b=0, sel_a} packed [3*INDEX_WIDTH-1:0] as C|B|A, zero-extended; o_bus_valid=1. Then MOVE/READ → READ, LOADI → WRITE.
- READ: command COM_READA, o_bus_valid=0. When i_bus_valid=1, capture i_bus_data; MOVE → WRITE, READ → RSP. While i_bus_valid=0, stay and count wait cycles.
- WRITE (1 cycle): command COM_LATCHC, o_bus_data = captured word (MOVE) or imm (LOADI), o_bus_valid=1. Issued even when sel_c=0; the slave discards it. Then → RSP.
- RSP: o_rsp_valid=1, data/error stable; on i_rsp_ready → IDLE.
- Error: i_bus_error high in any of SEL/READ/WRITE sets a sticky per-transaction error; cleared on acceptance of the next request.
- Bus outputs are registered from state; o_bus_data=0 and o_bus_valid=0 whenever the command is not LATCHSEL or LATCHC.

## Timing
- Reset (i_Reset_n low at an edge): state IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_data=0, o_rsp_error=0, o_bus_command=COM_NOP, o_bus_data=0, o_bus_valid=0, wait counter=0. Reset mid-transaction abandons it with no response; a partial LATCHSEL may already have reached the slave.
- Request accepted at edge N → SEL visible in cycle N+1.
- Latency from acceptance to o_rsp_valid, with a zero-wait slave: MOVE 4 cycles, READ 3 cycles, LOADI 3 cycles, reserved op 1 cycle.
- READ wait states add 1 cycle each.
- Back-to-back: the next request is accepted the cycle after the RSP handshake, because o_req_ready depends only on state.

## Configuration
- REGFILE_BUS_MASTER_TIMEOUT_EN defined: in READ, after TIMEOUT consecutive cycles with i_bus_valid=0, go to RSP with error=1, data=0. MOVE skips WRITE, so the destination is untouched.
- Undefined: no counter; READ waits indefinitely.

## Test plan
- Reset, then LOADI sel_c=2 imm=0x1234 → SEL drives COM_LATCHSEL with data 0x0080; WRITE drives COM_LATCHC with 0x1234; rsp data=0x1234, error=0, rsp_valid in cycle N+3.
- Slave r2=0x00AB, MOVE sel_a=2 sel_c=5 → READA captures 0xAB; LATCHC drives 0xAB; rsp in cycle N+4; slave r5=0x00AB.
- READ sel_a=0 → data=0, error=0; READ op with i_bus_valid held low 3 cycles → rsp at N+6 with the captured value.
- With TIMEOUT_EN and TIMEOUT=4, i_bus_valid stuck low on MOVE → error=1, data=0, no COM_LATCHC issued, rsp in cycle N+6.
- i_bus_error pulsed during WRITE of LOADI → rsp error=1; next request accepted with error cleared. Reserved op 3 → error=1 after 1 cycle, no bus commands.
- i_Reset_n asserted during READ → next cycle IDLE, COM_NOP, rsp_valid=0; a following LOADI completes normally; i_rsp_ready held low 5 cycles → response stable, o_req_ready=0 throughout.
